// File: rtl/asmd_dot_sequencer.sv
// asmd_dot_sequencer: feeds operand pairs to an external multiplier and accumulates a dot product
module asmd_dot_sequencer #(
    parameter int word_length = 8,
    parameter int vec_len     = 4,
    parameter int guard_bits  = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [word_length-1:0]              a_in,
    input  logic [word_length-1:0]              b_in,
    output logic [word_length-1:0]              mult_word0,
    output logic [word_length-1:0]              mult_word1,
    output logic                                mult_start,
    input  logic [2*word_length-1:0]            mult_product,
    input  logic                                mult_ready,
    output logic [2*word_length+guard_bits-1:0] acc_out,
    output logic                                out_valid,
    input  logic                                out_ready
);
    localparam int accw = 2*word_length + guard_bits;
    localparam int cw   = vec_len > 1 ? $clog2(vec_len) : 1;

    typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, WAIT_DONE, ACC, OUT} state_t;

    state_t          state;
    logic [accw-1:0] acc;
    logic [accw-1:0] acc_sum;
    logic [cw-1:0]   count;

    assign in_ready = (state == IDLE) && mult_ready;
    assign acc_sum  = acc + accw'(mult_product);

    // sequencer: latch pair, pulse start, track multiplier busy/done, accumulate, hold result until taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            acc        <= '0;
            count      <= '0;
            mult_word0 <= '0;
            mult_word1 <= '0;
            mult_start <= 1'b0;
            out_valid  <= 1'b0;
            acc_out    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid && mult_ready) begin
                    mult_word0 <= a_in;
                    mult_word1 <= b_in;
                    mult_start <= 1'b1;
                    state      <= START;
                end
                START: begin
                    mult_start <= 1'b0;
                    state      <= WAIT_BUSY;
                end
                WAIT_BUSY: if (!mult_ready) state <= WAIT_DONE;
                WAIT_DONE: if (mult_ready) state <= ACC;
                ACC: begin
                    acc   <= acc_sum;
                    count <= count + 1'b1;
                    if (count == cw'(vec_len - 1)) begin
                        out_valid <= 1'b1;
                        acc_out   <= acc_sum;
                        state     <= OUT;
                    end else begin
                        state <= IDLE;
                    end
                end
                OUT: if (out_ready) begin
                    out_valid <= 1'b0;
                    acc       <= '0;
                    count     <= '0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_asmd_dot_sequencer.sv
// tb_asmd_dot_sequencer: directed bench with a random-latency behavioural multiplier
module tb_asmd_dot_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        out_ready;
    logic [7:0]  a_in, b_in;
    logic        in_ready, mult_start, out_valid;
    logic [7:0]  mult_word0, mult_word1;
    logic [15:0] mult_product;
    logic        mult_ready;
    logic [19:0] acc_out;
    logic        in_ready_w, mult_start_w, out_valid_w;
    logic [7:0]  mult_word0_w, mult_word1_w;
    logic [15:0] acc_out_w;

    int checks = 0;
    int errors = 0;
    int n_start = 0;
    int busy;
    logic [7:0] w0_log [0:63];
    logic [7:0] w1_log [0:63];

    always #5 clk = ~clk;

    asmd_dot_sequencer #(.word_length(8), .vec_len(4), .guard_bits(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in), .mult_word0(mult_word0), .mult_word1(mult_word1),
        .mult_start(mult_start), .mult_product(mult_product), .mult_ready(mult_ready),
        .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready)
    );

    // wrap-around instance: same stimulus, no guard bits
    asmd_dot_sequencer #(.word_length(8), .vec_len(4), .guard_bits(0)) dut_wrap (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .a_in(a_in), .b_in(b_in), .mult_word0(mult_word0_w), .mult_word1(mult_word1_w),
        .mult_start(mult_start_w), .mult_product(mult_product), .mult_ready(mult_ready),
        .acc_out(acc_out_w), .out_valid(out_valid_w), .out_ready(out_ready)
    );

    // behavioural multiplier: ready drops for 3..9 cycles after sampling start
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mult_ready <= 1'b0;
            busy       <= 0;
        end else if (mult_start && mult_ready) begin
            mult_ready   <= 1'b0;
            busy         <= $urandom_range(3, 9);
            mult_product <= 16'(mult_word0) * 16'(mult_word1);
        end else if (!mult_ready) begin
            if (busy <= 1) mult_ready <= 1'b1;
            busy <= busy - 1;
        end
    end

    // log operands seen at each start pulse
    always @(posedge clk) begin
        if (mult_start) begin
            w0_log[n_start % 64] <= mult_word0;
            w1_log[n_start % 64] <= mult_word1;
            n_start <= n_start + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input bit stall);
        a_in = a;
        b_in = b;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (in_valid && in_ready) begin
                @(posedge clk);
                #1 in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        chk("send_timeout", 32'(in_ready), 1);
    endtask

    task automatic wait_out();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) return;
        end
        chk("out_timeout", 32'(out_valid), 1);
    endtask

    int base;

    initial begin
        reset = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        a_in = '0;
        b_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_acc_out", 32'(acc_out), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_mult_start", 32'(mult_start), 0);
        chk("rst_words", {16'd0, mult_word0, mult_word1}, 0);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 32'(mult_ready));

        // basic vector with one-cycle out_valid pulse
        base = n_start;
        for (int i = 0; i < 4; i++) send(8'(2*i+1), 8'(2*i+2), 1'b0);
        wait_out();
        chk("basic_acc", 32'(acc_out), 100);
        chk("basic_wrap_acc", 32'(acc_out_w), 100);
        @(negedge clk);
        chk("basic_pulse", 32'(out_valid), 0);
        chk("basic_starts", 32'(n_start - base), 4);
        for (int i = 0; i < 4; i++) begin
            chk("basic_w0", 32'(w0_log[(base+i) % 64]), 32'(2*i+1));
            chk("basic_w1", 32'(w1_log[(base+i) % 64]), 32'(2*i+2));
        end

        // max values held under backpressure; junk offered meanwhile must be ignored
        out_ready = 1'b0;
        base = n_start;
        for (int i = 0; i < 4; i++) send(8'd255, 8'd255, 1'b0);
        wait_out();
        chk("max_acc", 32'(acc_out), 260100);
        chk("wrap_acc", 32'(acc_out_w), 63492);
        for (int i = 0; i < 20; i++) begin
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_acc", 32'(acc_out), 260100);
            chk("bp_in_ready", 32'(in_ready), 0);
            in_valid = 1'b1;
            a_in = 8'd99;
            b_in = 8'd99;
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", 32'(out_valid), 0);
        chk("bp_starts", 32'(n_start - base), 4);

        // accumulator cleared after handshake
        for (int i = 0; i < 4; i++) send(8'd2, 8'd2, 1'b0);
        wait_out();
        chk("clear_acc", 32'(acc_out), 16);
        chk("clear_wrap_acc", 32'(acc_out_w), 16);

        // random in_valid stalls
        base = n_start;
        for (int i = 0; i < 4; i++) send(8'd10, 8'd10, 1'b1);
        wait_out();
        chk("stall_acc", 32'(acc_out), 400);
        chk("stall_starts", 32'(n_start - base), 4);
        @(negedge clk);

        // reset mid-vector discards the partial sum
        send(8'd1, 8'd1, 1'b0);
        send(8'd1, 8'd1, 1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_acc_out", 32'(acc_out), 0);
        chk("mid_rst_wrap_acc_out", 32'(acc_out_w), 0);
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_start", 32'(mult_start), 0);
        chk("mid_rst_words", {16'd0, mult_word0, mult_word1}, 0);
        chk("mid_rst_in_ready", 32'(in_ready), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'(mult_ready));
        for (int i = 0; i < 4; i++) send(8'd3, 8'd3, 1'b0);
        wait_out();
        chk("post_rst_acc", 32'(acc_out), 36);
        chk("post_rst_wrap_acc", 32'(acc_out_w), 36);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/asmd_dot_sequencer.md
ASMD_DOT_SEQUENCER -- requirements
Module: asmd_dot_sequencer

Interface
REQ-001 Parameter word_length, default 8: operand width in bits, matching the downstream asmd_multiplier.
REQ-002 Parameter vec_len, default 4: number of operand pairs per dot product, range 2..256.
REQ-003 Parameter guard_bits, default 4: extra accumulator bits; acc width ACCW = 2*word_length + guard_bits.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset: 0 resets immediately, 1 runs.
REQ-006 in_valid  input  1  operand pair on a_in/b_in is valid.
REQ-007 in_ready  output  1  block accepts an operand pair this cycle.
REQ-008 a_in, b_in  input  word_length each  unsigned operands.
REQ-009 mult_word0, mult_word1  output  word_length each  operands driven to the multiplier.
REQ-010 mult_start  output  1  one-cycle start pulse to the multiplier.
REQ-011 mult_product  input  2*word_length  multiplier result.
REQ-012 mult_ready  input  1  multiplier idle / result valid.
REQ-013 acc_out  output  ACCW  dot-product result.
REQ-014 out_valid  output  1  acc_out holds a complete result.
REQ-015 out_ready  input  1  consumer accepts the result.

Function
REQ-016 States SHALL be IDLE, START, WAIT_BUSY, WAIT_DONE, ACC, OUT.
REQ-017 IDLE: in_ready = mult_ready. On in_valid & in_ready, latch a_in/b_in into mult_word0/mult_word1 and go to START; otherwise stay.
REQ-018 START: mult_start=1 for exactly one cycle, then go to WAIT_BUSY. mult_start SHALL be 0 in every other state.
REQ-019 WAIT_BUSY: stay while mult_ready=1; go to WAIT_DONE on the first cycle mult_ready=0. The multiplier contract is that ready deasserts for at least one cycle after sampling start.
REQ-020 WAIT_DONE: stay while mult_ready=0; go to ACC when mult_ready=1.
REQ-021 ACC: acc <= acc + zero-extended mult_product, modulo 2^ACCW (wrap-around, no saturation, no flag); count <= count+1.
REQ-022 From ACC: go to OUT if count was vec_len-1 before the increment, else go to IDLE.
REQ-023 OUT: out_valid=1 and acc_out=acc, held stable until out_ready=1.
REQ-024 OUT with out_ready=1: the handshake completes that cycle; clear acc and count, go to IDLE.
REQ-025 Backpressure: no operand is accepted while in OUT. in_ready=0 in every state except IDLE.
REQ-026 mult_word0/mult_word1 SHALL stay stable from the latch until the next accepted pair.
REQ-027 Minimum accept-to-accept spacing SHALL be 5 cycles plus multiplier busy time.
REQ-028 With a zero-wait consumer, the last pair's ACC cycle is followed by out_valid on the next cycle.
REQ-029 in_valid during a non-IDLE state SHALL be ignored; the upstream holds data until in_ready.
REQ-030 mult_ready=1 in WAIT_DONE on the same cycle as an async reset assertion: reset wins.
REQ-031 Operand values and the accumulator are unsigned.

Reset
REQ-032 On reset=0, asynchronously force:
- state=IDLE, acc=0, count=0
- mult_word0=0, mult_word1=0, mult_start=0
- out_valid=0, acc_out=0
REQ-033 A reset asserted mid-vector or in OUT SHALL discard the partial sum. After release, the first accepted pair starts a new vector.
REQ-034 in_ready after reset release SHALL follow mult_ready.

Verification
REQ-035 The bench SHALL use word_length=8, vec_len=4, guard_bits=4 with a behavioural multiplier whose busy time is 3..9 cycles (random).
REQ-036 Basic: pairs (1,2), (3,4), (5,6), (7,8), out_ready=1 -> acc_out=100 with a one-cycle out_valid pulse; exactly 4 mult_start pulses, each preceded by correct mult_word0/1.
REQ-037 Max values: four pairs (255,255) -> acc_out=260100 (0x3F804), no wrap.
REQ-038 Backpressure: out_ready=0 for 20 cycles after out_valid rises -> acc_out and out_valid are stable, in_ready=0 throughout. Then out_ready=1 -> the next vector (2,2)x4 gives acc_out=16, proving acc was cleared.
REQ-039 Stall: in_valid toggled 1/0 randomly, pairs (10,10)x4 -> acc_out=400. No pair is lost or duplicated; the start count equals 4.
REQ-040 Reset mid-vector: reset=0 after 2 pairs (1,1), (1,1), then release. Then (3,3)x4 -> acc_out=36, and all outputs read 0 during reset.
REQ-041 Wrap: with guard_bits=0, four pairs (255,255) -> acc_out = 260100 mod 65536 = 63492.
